pnser_arb: RTL and testbench
============================

Name: pnser_arb

Overview:
- Round-robin scheduler that shares one pnser PN serializer among NREQ requesters.
- Each requester presents a 32-bit word and a 5-bit length. The arbiter picks one winner and stages its word in a holding slot that drives the serializer's rnd_i/rnd_len.
- The slot is consumed when the serializer pulses ack.
- When no word is staged, the arbiter feeds a programmable idle word, so the serial line never starves.

Parameters:
- NREQ, 4, number of requesters (2..4); source ids are 0..NREQ-1.
- IDLE_WORD, 32'h00000000, word presented when the slot is empty.
- IDLE_LEN, 5'h8, length presented with IDLE_WORD.
- CNT_W, 16, width of the status counters.

Ports:
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  grant enable. Low blocks new grants; an already staged word is still delivered.
- req_i  in  NREQ  per-requester request; held until granted.
- req_dat_i  in  32*NREQ  word of requester k at bits [32k+31:32k].
- req_len_i  in  5*NREQ  length of requester k at bits [5k+4:5k].
- gnt_o  out  NREQ  one-hot, one-cycle pulse: the requester's word was captured into the slot.
- ser_ack_i  in  1  serializer ack: pulses the cycle rnd_i/rnd_len are sampled.
- ser_rnd_o  out  32  to pnser rnd_i (registered).
- ser_len_o  out  5  to pnser rnd_len (registered).
- cur_src_o  out  3  source of the word currently serialized; 3'b111 = idle word.
- busy_o  out  1  slot loaded.
- word_cnt_o  out  CNT_W  requester words consumed by the serializer; saturating.
- idle_cnt_o  out  CNT_W  idle words consumed; saturating.

Behaviour:
- Slot state machine: EMPTY, LOADED. busy_o = (state == LOADED).
- Reset values:
  - state = EMPTY, rr_ptr = 0, gnt_o = 0
  - ser_rnd_o = IDLE_WORD, ser_len_o = IDLE_LEN
  - cur_src_o = 3'b111, counters = 0
- Reset wins over all other inputs in the same cycle. Reset mid-word drops any staged word and issues no grant.
- Winner selection (combinational): scan requesters starting at rr_ptr, wrapping modulo NREQ. The first asserted req_i wins.
- Load condition: en_i && |req_i && (state == EMPTY || ser_ack_i).
  - On load: the slot registers the winner's dat/len, gnt_o[winner] = 1 for that cycle only, state = LOADED, rr_ptr = (winner+1) mod NREQ.
  - The new word appears on ser_rnd_o/ser_len_o the next cycle.
  - Requesters sample gnt_o at the edge. They either drop req_i or present the next word the following cycle.
- On ser_ack_i with state LOADED:
  - cur_src_o takes the slot's source id next cycle; word_cnt_o increments.
  - If no load occurs the same cycle: state = EMPTY, and ser_rnd_o/ser_len_o return to IDLE_WORD/IDLE_LEN next cycle.
- On ser_ack_i with state EMPTY:
  - cur_src_o = 3'b111 next cycle; idle_cnt_o increments.
  - If a load occurs the same cycle, the idle word is still the one consumed. The new word is staged for the next ack.
- Simultaneous ack and load: the consumed word is the old slot content. The new winner overwrites the slot at the same edge, giving back-to-back words with zero idle gap.
- A staged word is never overwritten without an intervening ser_ack_i. In LOADED without ack, no grant is issued even if requests are pending.
- en_i low: no grants and rr_ptr frozen; the staged word is still delivered.
- Lengths pass through unchanged; 0 is legal and is forwarded as-is.
- Counters saturate at all-ones and do not wrap.

Test Plan:
- Reset, idle bench (all req low), ack every 10 cycles:
  - ser_rnd_o = 32'h0 and ser_len_o = 8 throughout; cur_src_o = 7; idle_cnt_o = 3 after 3 acks; gnt_o never asserted.
- Single request: req_i[2] with 32'hAB000000/len 8 while EMPTY:
  - gnt_o = 4'b0100 for one cycle; next cycle ser_rnd_o = 32'hAB000000 and ser_len_o = 8, busy_o = 1.
  - After the ack: cur_src_o = 2, word_cnt_o = 1; outputs revert to the idle word.
- Round robin: all four requests held, each re-presented after its grant:
  - Grant order 0,1,2,3,0 across consecutive acks.
  - Ack coincident with LOADED gives zero idle gap; idle_cnt_o unchanged.
- Simultaneous event: slot LOADED with 32'h9AB00000/len 12, ack and req_i[1] in the same cycle:
  - The 9AB word is consumed; gnt_o[1] pulses; the new word appears next cycle; state stays LOADED.
- Backpressure and en_i: LOADED, no ack for 20 cycles with req_i = 4'b1111:
  - No gnt_o pulses; ser_rnd_o stable.
  - With en_i = 0 when the ack arrives: slot empties, no grant is issued, and rr_ptr is unchanged.
- Reset mid-operation: rst_i asserted while LOADED with req_i[3] high:
  - Next cycle outputs are at reset values, the staged word is lost, and gnt_o = 0 during reset.
  - After release, the first grant goes to requester 0 if it is requesting.

Source files
------------

// File: rtl/pnser_arb.sv
// pnser_arb: round-robin arbiter staging one requester word at a time for a pnser serializer
//   clk_i, rst_i         clock, synchronous active-high reset
//   en_i                 grant enable (low blocks new grants only)
//   req_i/req_dat_i/req_len_i  per-requester request, 32-bit word, 5-bit length
//   gnt_o                one-hot pulse when a requester's word enters the slot
//   ser_ack_i            serializer consumed ser_rnd_o/ser_len_o this cycle
//   ser_rnd_o/ser_len_o  registered word/length to the serializer (idle word when empty)
//   cur_src_o            source of the word being serialized, 3'b111 for the idle word
//   busy_o               slot loaded
//   word_cnt_o/idle_cnt_o  saturating counts of consumed requester/idle words
module pnser_arb #(
  parameter int          NREQ      = 4,
  parameter logic [31:0] IDLE_WORD = 32'h0000_0000,
  parameter logic [4:0]  IDLE_LEN  = 5'h8,
  parameter int          CNT_W     = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [NREQ-1:0]     req_i,
  input  logic [32*NREQ-1:0]  req_dat_i,
  input  logic [5*NREQ-1:0]   req_len_i,
  output logic [NREQ-1:0]     gnt_o,
  input  logic                ser_ack_i,
  output logic [31:0]         ser_rnd_o,
  output logic [4:0]          ser_len_o,
  output logic [2:0]          cur_src_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    word_cnt_o,
  output logic [CNT_W-1:0]    idle_cnt_o
);
  localparam int PW = (NREQ > 2) ? 2 : 1;
  typedef enum logic {EMPTY, LOADED} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, win;
  logic [2:0] slot_src;
  logic load;
  // scan from the farthest offset back so the nearest requester to rr_ptr wins
  always_comb begin
    win = rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_i[(int'(rr_ptr) + i) % NREQ]) win = PW'((int'(rr_ptr) + i) % NREQ);
  end
  assign load = en_i && |req_i && (state == EMPTY || ser_ack_i);
  always_ff @(posedge clk_i)
    state <= rst_i ? EMPTY : state_nx;
  always_comb
    state_nx = load ? LOADED : (ser_ack_i ? EMPTY : state);
  always_comb
    busy_o = state == LOADED;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      gnt_o      <= '0;
      slot_src   <= 3'b111;
      ser_rnd_o  <= IDLE_WORD;
      ser_len_o  <= IDLE_LEN;
      cur_src_o  <= 3'b111;
      word_cnt_o <= '0;
      idle_cnt_o <= '0;
    end else begin
      gnt_o <= load ? NREQ'(1) << win : '0;
      if (load) begin
        ser_rnd_o <= req_dat_i[32*int'(win) +: 32];
        ser_len_o <= req_len_i[5*int'(win) +: 5];
        slot_src  <= 3'(win);
        rr_ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
      end else if (ser_ack_i) begin
        ser_rnd_o <= IDLE_WORD;
        ser_len_o <= IDLE_LEN;
      end
      // an ack always consumes what was on the line before this edge
      if (ser_ack_i) begin
        cur_src_o <= (state == LOADED) ? slot_src : 3'b111;
        if (state == LOADED && !(&word_cnt_o)) word_cnt_o <= word_cnt_o + CNT_W'(1);
        if (state == EMPTY && !(&idle_cnt_o)) idle_cnt_o <= idle_cnt_o + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_pnser_arb.sv
// tb_pnser_arb: directed and randomized checks of pnser_arb against a queue-based reference model
module tb_pnser_arb;
  localparam int NREQ = 4;
  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst, en, ack;
  logic [NREQ-1:0] req, gnt;
  logic [31:0] dat [NREQ];
  logic [4:0] len [NREQ];
  logic [32*NREQ-1:0] req_dat;
  logic [5*NREQ-1:0] req_len;
  logic [31:0] ser_rnd;
  logic [4:0] ser_len;
  logic [2:0] cur_src;
  logic busy;
  logic [CW-1:0] word_cnt, idle_cnt;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [31:0] d; logic [4:0] l; int s;} ent_t;
  ent_t q[$];
  int m_rr, m_cur, m_wc, m_ic;
  logic [NREQ-1:0] m_gnt;
  logic [NREQ-1:0] rq_v;

  assign req_dat = {dat[3], dat[2], dat[1], dat[0]};
  assign req_len = {len[3], len[2], len[1], len[0]};
  always #5 clk = ~clk;

  pnser_arb #(.NREQ(NREQ), .IDLE_WORD(32'h0), .IDLE_LEN(5'h8), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .req_dat_i(req_dat), .req_len_i(req_len),
    .gnt_o(gnt), .ser_ack_i(ack), .ser_rnd_o(ser_rnd), .ser_len_o(ser_len), .cur_src_o(cur_src),
    .busy_o(busy), .word_cnt_o(word_cnt), .idle_cnt_o(idle_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // apply one cycle of inputs, advance the reference model, compare every output
  task automatic step(input logic r, input logic e, input logic [NREQ-1:0] rq, input logic a);
    int w;
    rst = r; en = e; req = rq; ack = a;
    @(posedge clk);
    if (r) begin
      q.delete(); m_rr = 0; m_gnt = '0; m_cur = 7; m_wc = 0; m_ic = 0;
    end else begin
      bit ld;
      ld = e && rq != '0 && (q.size() == 0 || a);
      if (a) begin
        if (q.size() != 0) begin
          m_cur = q[0].s; q.delete(0); m_wc = (m_wc < MAXC) ? m_wc + 1 : m_wc;
        end else begin
          m_cur = 7; m_ic = (m_ic < MAXC) ? m_ic + 1 : m_ic;
        end
      end
      m_gnt = '0;
      if (ld) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && rq[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
        q.push_back('{dat[w], len[w], w});
        m_gnt[w] = 1'b1;
        m_rr = (w + 1) % NREQ;
      end
    end
    #1;
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("ser_rnd", ser_rnd, q.size() != 0 ? q[0].d : 32'h0);
    chk("ser_len", 32'(ser_len), q.size() != 0 ? 32'(q[0].l) : 32'd8);
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("cur_src", 32'(cur_src), 32'(m_cur));
    chk("word_cnt", 32'(word_cnt), 32'(m_wc));
    chk("idle_cnt", 32'(idle_cnt), 32'(m_ic));
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin dat[k] = 32'h0; len[k] = 5'h0; end
    repeat (3) step(1, 1, '0, 0);
    chk("rst_cur_src", 32'(cur_src), 32'h7);
    chk("rst_rnd", ser_rnd, 32'h0);
    for (int i = 0; i < 30; i++) step(0, 1, '0, (i % 10) == 9);
    chk("idle_cnt3", 32'(idle_cnt), 32'd3);
    chk("idle_rnd", ser_rnd, 32'h0);
    dat[2] = 32'hAB00_0000; len[2] = 5'd8;
    step(0, 1, 4'b0100, 0);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_rnd", ser_rnd, 32'hAB00_0000);
    chk("single_busy", 32'(busy), 32'h1);
    step(0, 1, '0, 0);
    chk("single_gnt_off", 32'(gnt), 32'h0);
    step(0, 1, '0, 1);
    chk("single_src", 32'(cur_src), 32'h2);
    chk("single_wc", 32'(word_cnt), 32'h1);
    chk("single_revert", ser_rnd, 32'h0);
    step(1, 1, '0, 0);
    for (int k = 0; k < NREQ; k++) begin dat[k] = 32'hC000_0000 | k; len[k] = 5'(k + 3); end
    step(0, 1, 4'b1111, 0);
    chk("rr_g0", 32'(gnt), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 4'b1111, 1);
      chk("rr_gnt", 32'(gnt), 32'(1 << (i % NREQ)));
      chk("rr_src", 32'(cur_src), 32'(i - 1));
    end
    chk("rr_idle", 32'(idle_cnt), 32'h0);
    step(0, 1, '0, 1);
    dat[0] = 32'h9AB0_0000; len[0] = 5'd12;
    step(0, 1, 4'b0001, 0);
    dat[1] = 32'h1234_5678; len[1] = 5'd0;
    step(0, 1, 4'b0010, 1);
    chk("sim_src", 32'(cur_src), 32'h0);
    chk("sim_gnt", 32'(gnt), 32'h2);
    chk("sim_rnd", ser_rnd, 32'h1234_5678);
    chk("sim_len0", 32'(ser_len), 32'h0);
    chk("sim_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 4'b1111, 0);
      chk("bp_gnt", 32'(gnt), 32'h0);
      chk("bp_rnd", ser_rnd, 32'h1234_5678);
    end
    step(0, 0, 4'b1111, 1);
    chk("en_busy", 32'(busy), 32'h0);
    chk("en_gnt", 32'(gnt), 32'h0);
    step(0, 1, 4'b1111, 0);
    chk("en_rr", 32'(gnt), 32'h4);
    step(1, 1, 4'b1000, 0);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_src", 32'(cur_src), 32'h7);
    step(0, 1, 4'b1001, 0);
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    rq_v = '0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 600) == 0, ($urandom % 10) != 0, rq_v, ($urandom % 3) == 0);
      for (int k = 0; k < NREQ; k++) begin
        if (gnt[k] || (!rq_v[k] && ($urandom % 3) == 0)) begin
          rq_v[k] = gnt[k] ? 1'($urandom % 2) : 1'b1;
          dat[k] = $urandom;
          len[k] = 5'($urandom);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
